// File: rtl/dm_responder.sv
// Data-memory responder: REQ/ACK load/store port with a programmable wait and access-error flagging.
// Optional store trace printing is enabled by defining DM_DISPLAY_EN.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [1:0]  SelectBit,
  input  logic        ExtendSign,
  input  logic [31:0] PC,
  output logic        ACK,
  output logic [31:0] RD,
  output logic        ERR,
  output logic        BUSY
);

  // state  | meaning
  // S_IDLE | waiting for REQ; accepts and latches the request fields
  // S_WAIT | counting LATENCY cycles before commit
  // S_RESP | ACK/RD/ERR presented for one cycle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q, ext_q;
  logic [31:0] a_q, wd_q;
  logic [1:0]  sel_q;
  logic [31:0] mem [2**ADDR_W];

  logic              we_e, ext_e;
  logic [31:0]       a_e, wd_e;
  logic [1:0]        sel_e;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       cur, merged, ld, rd_c;
  logic [15:0]       half;
  logic [7:0]        bytev;
  logic              err_c, commit;

  // With LATENCY = 0 the commit happens on the accepting edge, so use the live inputs then.
  always_comb begin
    we_e  = (state == S_IDLE) ? WE : we_q;
    a_e   = (state == S_IDLE) ? A : a_q;
    wd_e  = (state == S_IDLE) ? WD : wd_q;
    sel_e = (state == S_IDLE) ? SelectBit : sel_q;
    ext_e = (state == S_IDLE) ? ExtendSign : ext_q;
  end

  always_comb begin
    idx   = a_e[ADDR_W+1:2];
    cur   = mem[idx];
    err_c = (sel_e == 2'd3) ||
            ((sel_e == 2'd0) && (a_e[1:0] != 2'b00)) ||
            ((sel_e == 2'd1) && a_e[0]) ||
            (a_e[31:ADDR_W+2] != '0);
    merged = cur;
    case (sel_e)
      2'd0:    merged = wd_e;
      2'd1:    merged[{a_e[1], 4'b0000} +: 16] = wd_e[15:0];
      2'd2:    merged[{a_e[1:0], 3'b000} +: 8] = wd_e[7:0];
      default: merged = cur;
    endcase
    half  = cur[{a_e[1], 4'b0000} +: 16];
    bytev = cur[{a_e[1:0], 3'b000} +: 8];
    case (sel_e)
      2'd1:    ld = ext_e ? {16'h0000, half} : {{16{half[15]}}, half};
      2'd2:    ld = ext_e ? {24'h000000, bytev} : {{24{bytev[7]}}, bytev};
      default: ld = cur;
    endcase
    rd_c   = (we_e || err_c) ? 32'h0 : ld;
    commit = ((state == S_IDLE) && REQ && (LATENCY == 0)) ||
             ((state == S_WAIT) && (cnt == 4'd0));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      ACK   <= 1'b0;
      RD    <= 32'h0;
      ERR   <= 1'b0;
      BUSY  <= 1'b0;
      we_q  <= 1'b0;
      ext_q <= 1'b0;
      a_q   <= 32'h0;
      wd_q  <= 32'h0;
      sel_q <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          ACK <= 1'b0;
          RD  <= 32'h0;
          ERR <= 1'b0;
          if (REQ) begin
            we_q  <= WE;
            ext_q <= ExtendSign;
            a_q   <= A;
            wd_q  <= WD;
            sel_q <= SelectBit;
            BUSY  <= 1'b1;
            if (LATENCY == 0) begin
              state <= S_RESP;
              ACK   <= 1'b1;
              RD    <= rd_c;
              ERR   <= err_c;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
            ACK   <= 1'b1;
            RD    <= rd_c;
            ERR   <= err_c;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ACK   <= 1'b0;
          RD    <= 32'h0;
          ERR   <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DM_DISPLAY_EN
  logic [31:0] pc_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      pc_q <= 32'h0;
    else if ((state == S_IDLE) && REQ)
      pc_q <= PC;
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 32'h0;
    end else if (commit && we_e && !err_c) begin
      mem[idx] <= merged;
`ifdef DM_DISPLAY_EN
      $display("%d@%h: *%h <= %h", $time, (state == S_IDLE) ? PC : pc_q,
               {a_e[31:2], 2'b00}, merged);
`endif
    end
  end

endmodule
